// File: rtl/cpu_defines.sv
// Shared CPU definitions: operation enum, MIPS opcode/funct encodings and
// common type aliases used by the decode stage.
package cpu_defines;

   typedef logic [4:0]  Reg_addr_t;
   typedef logic [31:0] Inst_t;
   typedef logic [31:0] Inst_addr_t;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_OR   = 3'd1,
      OP_AND  = 3'd2,
      OP_XOR  = 3'd3,
      OP_ADDU = 3'd4,
      OP_SUBU = 3'd5,
      OP_SLT  = 3'd6,
      OP_LUI  = 3'd7
   } Oper_t;

   localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
   localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
   localparam logic [5:0] OPCODE_SLTI    = 6'h0A;
   localparam logic [5:0] OPCODE_ANDI    = 6'h0C;
   localparam logic [5:0] OPCODE_ORI     = 6'h0D;
   localparam logic [5:0] OPCODE_XORI    = 6'h0E;
   localparam logic [5:0] OPCODE_LUI     = 6'h0F;

   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder: instruction word to operation, source
// usage, extended immediate and destination. An instruction whose write is
// suppressed (destination $0) has no architectural effect, so its sources
// are also dropped and never take part in hazard checks.
module id_decoder
   import cpu_defines::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [31:0]           i_inst,
   output Oper_t                 o_oper,
   output logic                  o_use_rs,
   output logic                  o_use_rt,
   output logic                  o_use_imm,
   output logic [DATA_W-1:0]     o_imm_ext,
   output logic                  o_we,
   output logic [REG_ADDR_W-1:0] o_waddr
);

   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   Reg_addr_t   w_rt;
   Reg_addr_t   w_rd;
   logic [15:0] w_imm;
   Reg_addr_t   w_dst;
   logic        w_wr;
   logic        w_rs_u;
   logic        w_rt_u;
   Oper_t       w_oper;

   assign w_opcode = i_inst[31:26];
   assign w_rt     = i_inst[20:16];
   assign w_rd     = i_inst[15:11];
   assign w_imm    = i_inst[15:0];
   assign w_funct  = i_inst[5:0];

   // Main decode table; unknown encodings fall through to a sourceless NOP
   always_comb begin
      w_oper    = OP_NOP;
      w_rs_u    = 1'b0;
      w_rt_u    = 1'b0;
      o_use_imm = 1'b0;
      o_imm_ext = '0;
      w_dst     = '0;
      w_wr      = 1'b0;
      case (w_opcode)
         OPCODE_ORI, OPCODE_ANDI, OPCODE_XORI: begin
            w_oper    = (w_opcode == OPCODE_ORI)  ? OP_OR  :
                        (w_opcode == OPCODE_ANDI) ? OP_AND : OP_XOR;
            w_rs_u    = 1'b1;
            o_use_imm = 1'b1;
            o_imm_ext = DATA_W'(w_imm);
            w_dst     = w_rt;
            w_wr      = 1'b1;
         end
         OPCODE_ADDIU, OPCODE_SLTI: begin
            w_oper    = (w_opcode == OPCODE_ADDIU) ? OP_ADDU : OP_SLT;
            w_rs_u    = 1'b1;
            o_use_imm = 1'b1;
            o_imm_ext = DATA_W'($signed(w_imm));
            w_dst     = w_rt;
            w_wr      = 1'b1;
         end
         OPCODE_LUI: begin
            w_oper    = OP_LUI;
            o_use_imm = 1'b1;
            o_imm_ext = DATA_W'({w_imm, 16'h0000});
            w_dst     = w_rt;
            w_wr      = 1'b1;
         end
         OPCODE_SPECIAL: begin
            w_rs_u = 1'b1;
            w_rt_u = 1'b1;
            w_dst  = w_rd;
            w_wr   = 1'b1;
            case (w_funct)
               FUNCT_OR:   w_oper = OP_OR;
               FUNCT_AND:  w_oper = OP_AND;
               FUNCT_XOR:  w_oper = OP_XOR;
               FUNCT_ADDU: w_oper = OP_ADDU;
               FUNCT_SUBU: w_oper = OP_SUBU;
               FUNCT_SLT:  w_oper = OP_SLT;
               default: begin
                  w_oper = OP_NOP;
                  w_rs_u = 1'b0;
                  w_rt_u = 1'b0;
                  w_dst  = '0;
                  w_wr   = 1'b0;
               end
            endcase
         end
         default: ;
      endcase
   end

   assign o_oper   = w_oper;
   assign o_we     = w_wr && (w_dst != '0);
   assign o_use_rs = w_rs_u && (w_dst != '0);
   assign o_use_rt = w_rt_u && (w_dst != '0);
   assign o_waddr  = REG_ADDR_W'(w_dst);

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, EX/MEM bypass,
// load-use interlock and the registered ID/EX latch.
// Build option FORWARD_EN: when defined, operands bypass from EX/MEM and only
// load-use stalls; when undefined, operands come from the register file and
// any pending EX/MEM write to a used source stalls.
module id_stage
   import cpu_defines::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid,
   input  logic [31:0]           if_pc,
   input  logic [31:0]           if_inst,
   output logic                  id_ready,
   output logic [REG_ADDR_W-1:0] rf_raddr1,
   output logic [REG_ADDR_W-1:0] rf_raddr2,
   input  logic [DATA_W-1:0]     rf_rdata1,
   input  logic [DATA_W-1:0]     rf_rdata2,
   input  logic                  ex_we,
   input  logic [REG_ADDR_W-1:0] ex_waddr,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic                  ex_is_load,
   input  logic                  mem_we,
   input  logic [REG_ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0]     mem_wdata,
   input  logic                  ex_ready,
   input  logic                  flush,
   output logic                  idex_valid,
   output logic [31:0]           idex_pc,
   output Oper_t                 idex_oper,
   output logic [DATA_W-1:0]     idex_reg1,
   output logic [DATA_W-1:0]     idex_reg2,
   output logic                  idex_we,
   output logic [REG_ADDR_W-1:0] idex_waddr
);

   Oper_t                 w_oper;
   logic                  w_use_rs;
   logic                  w_use_rt;
   logic                  w_use_imm;
   logic [DATA_W-1:0]     w_imm_ext;
   logic                  w_we;
   logic [REG_ADDR_W-1:0] w_waddr;
   logic [REG_ADDR_W-1:0] w_rs;
   logic [REG_ADDR_W-1:0] w_rt;
   logic [DATA_W-1:0]     w_src1;
   logic [DATA_W-1:0]     w_src2;
   logic [DATA_W-1:0]     w_reg1;
   logic [DATA_W-1:0]     w_reg2;
   logic                  w_stall;
   logic                  w_advance;

   logic                  r_valid;
   logic [31:0]           r_pc;
   Oper_t                 r_oper;
   logic [DATA_W-1:0]     r_reg1;
   logic [DATA_W-1:0]     r_reg2;
   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_waddr;

   id_decoder #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_dec (
      .i_inst    (if_inst),
      .o_oper    (w_oper),
      .o_use_rs  (w_use_rs),
      .o_use_rt  (w_use_rt),
      .o_use_imm (w_use_imm),
      .o_imm_ext (w_imm_ext),
      .o_we      (w_we),
      .o_waddr   (w_waddr)
   );

   assign w_rs      = REG_ADDR_W'(if_inst[25:21]);
   assign w_rt      = REG_ADDR_W'(if_inst[20:16]);
   assign rf_raddr1 = w_rs;
   assign rf_raddr2 = w_rt;

`ifdef FORWARD_EN
   // Bypass selection: youngest producer (EX) wins over MEM, $0 never bypasses
   always_comb begin
      w_src1 = rf_rdata1;
      w_src2 = rf_rdata2;
      if (ex_we && ex_waddr == w_rs && w_rs != '0)
         w_src1 = ex_wdata;
      else if (mem_we && mem_waddr == w_rs && w_rs != '0)
         w_src1 = mem_wdata;
      if (ex_we && ex_waddr == w_rt && w_rt != '0)
         w_src2 = ex_wdata;
      else if (mem_we && mem_waddr == w_rt && w_rt != '0)
         w_src2 = mem_wdata;
   end

   // Only a load in EX cannot be bypassed in time
   always_comb begin
      w_stall = ex_is_load && ex_we && (ex_waddr != '0) &&
                ((w_use_rs && ex_waddr == w_rs) || (w_use_rt && ex_waddr == w_rt));
   end

   logic w_unused;
   assign w_unused = &{1'b0, if_inst[10:6]};
`else
   assign w_src1 = rf_rdata1;
   assign w_src2 = rf_rdata2;

   // Without bypass, any in-flight write to a used source must drain first
   always_comb begin
      w_stall = 1'b0;
      if (w_use_rs && w_rs != '0 &&
          ((ex_we && ex_waddr == w_rs) || (mem_we && mem_waddr == w_rs)))
         w_stall = 1'b1;
      if (w_use_rt && w_rt != '0 &&
          ((ex_we && ex_waddr == w_rt) || (mem_we && mem_waddr == w_rt)))
         w_stall = 1'b1;
   end

   logic w_unused;
   assign w_unused = &{1'b0, ex_wdata, mem_wdata, ex_is_load, if_inst[10:6]};
`endif

   // Operand assembly: unused register slots are zero, I-type reg2 is the immediate
   always_comb begin
      w_reg1 = w_use_rs ? w_src1 : '0;
      w_reg2 = w_use_rt ? w_src2 : (w_use_imm ? w_imm_ext : '0);
   end

   assign w_advance = ex_ready || !r_valid;
   assign id_ready  = !w_stall && w_advance && !flush;

   // ID/EX latch: reset, flush, load on accept, bubble when advancing without accept
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_oper  <= OP_NOP;
         r_reg1  <= '0;
         r_reg2  <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_oper  <= OP_NOP;
         r_we    <= 1'b0;
      end else if (w_advance) begin
         if (if_valid && !w_stall) begin
            r_valid <= 1'b1;
            r_pc    <= if_pc;
            r_oper  <= w_oper;
            r_reg1  <= w_reg1;
            r_reg2  <= w_reg2;
            r_we    <= w_we;
            r_waddr <= w_waddr;
         end else begin
            r_valid <= 1'b0;
            r_oper  <= OP_NOP;
            r_we    <= 1'b0;
         end
      end
   end

   assign idex_valid = r_valid;
   assign idex_pc    = r_pc;
   assign idex_oper  = r_oper;
   assign idex_reg1  = r_reg1;
   assign idex_reg2  = r_reg2;
   assign idex_we    = r_we;
   assign idex_waddr = r_waddr;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode/extension, bypass or interlock
// (depending on FORWARD_EN), load-use bubble, hold, flush and reset.
module tb_id_stage;
   import cpu_defines::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_valid;
   logic [31:0]   if_pc;
   logic [31:0]   if_inst;
   logic          id_ready;
   logic [AW-1:0] rf_raddr1, rf_raddr2;
   logic [DW-1:0] rf_rdata1, rf_rdata2;
   logic          ex_we, ex_is_load, mem_we, ex_ready, flush;
   logic [AW-1:0] ex_waddr, mem_waddr;
   logic [DW-1:0] ex_wdata, mem_wdata;
   logic          idex_valid, idex_we;
   logic [31:0]   idex_pc;
   Oper_t         idex_oper;
   logic [DW-1:0] idex_reg1, idex_reg2;
   logic [AW-1:0] idex_waddr;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_hold;

   always #5 clk = ~clk;

   // Register file model: $0 reads zero, $n reads 0x1000+n
   assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : 32'h1000 + 32'(rf_raddr1);
   assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : 32'h1000 + 32'(rf_raddr2);

   id_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .ex_ready(ex_ready), .flush(flush),
      .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_oper(idex_oper),
      .idex_reg1(idex_reg1), .idex_reg2(idex_reg2),
      .idex_we(idex_we), .idex_waddr(idex_waddr)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
      if_valid = 1'b1;
      if_pc    = pc;
      if_inst  = inst;
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
      ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_is_load = 1'b0;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; ex_ready = 1'b0;
      step(); step();
      chk("rst_valid", 64'(idex_valid), 64'd0);
      chk("rst_oper",  64'(idex_oper),  64'(OP_NOP));
      chk("rst_we",    64'(idex_we),    64'd0);
      chk("rst_waddr", 64'(idex_waddr), 64'd0);
      chk("rst_reg1",  64'(idex_reg1),  64'd0);
      chk("rst_reg2",  64'(idex_reg2),  64'd0);
      chk("rst_pc",    64'(idex_pc),    64'd0);

      // ORI $1,$0,0x8001: zero-extended immediate
      rst = 1'b0; ex_ready = 1'b1;
      issue(32'h100, 32'h3401_8001);
      chk("ori_ready", 64'(id_ready),  64'd1);
      chk("ori_raddr2", 64'(rf_raddr2), 64'd1);
      step();
      chk("ori_valid", 64'(idex_valid), 64'd1);
      chk("ori_reg1",  64'(idex_reg1),  64'd0);
      chk("ori_reg2",  64'(idex_reg2),  64'h0000_8001);
      chk("ori_waddr", 64'(idex_waddr), 64'd1);
      chk("ori_we",    64'(idex_we),    64'd1);
      chk("ori_oper",  64'(idex_oper),  64'(OP_OR));
      chk("ori_pc",    64'(idex_pc),    64'h100);

      // ADDIU $2,$0,0xFFFF: sign-extended
      issue(32'h104, 32'h2402_FFFF);
      step();
      chk("addiu_reg2", 64'(idex_reg2), 64'hFFFF_FFFF);
      chk("addiu_oper", 64'(idex_oper), 64'(OP_ADDU));

      // LUI $3,0x1234
      issue(32'h108, 32'h3C03_1234);
      step();
      chk("lui_reg2", 64'(idex_reg2), 64'h1234_0000);
      chk("lui_reg1", 64'(idex_reg1), 64'd0);
      chk("lui_oper", 64'(idex_oper), 64'(OP_LUI));

      // ANDI $8,$9,0xF0: rs read from register file
      issue(32'h10C, 32'h3128_00F0);
      step();
      chk("andi_reg1",  64'(idex_reg1),  64'h1009);
      chk("andi_reg2",  64'(idex_reg2),  64'hF0);
      chk("andi_waddr", 64'(idex_waddr), 64'd8);

      // OR $5,$4,$4 with $4 pending in both EX and MEM
      ex_we = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'hAA;
      mem_we = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'hBB;
      issue(32'h110, 32'h0084_2825);
`ifdef FORWARD_EN
      chk("fwd_ex_ready", 64'(id_ready), 64'd1);
      step();
      chk("fwd_ex_reg1", 64'(idex_reg1), 64'hAA);
      chk("fwd_ex_reg2", 64'(idex_reg2), 64'hAA);
      ex_waddr = 5'd0;
      issue(32'h114, 32'h0084_2825);
      chk("fwd_mem_ready", 64'(id_ready), 64'd1);
      step();
      chk("fwd_mem_reg1", 64'(idex_reg1), 64'hBB);
      chk("fwd_mem_reg2", 64'(idex_reg2), 64'hBB);
`else
      chk("nofwd_both_ready", 64'(id_ready), 64'd0);
      step();
      chk("nofwd_bub1_valid", 64'(idex_valid), 64'd0);
      ex_we = 1'b0; #1;
      chk("nofwd_mem_ready", 64'(id_ready), 64'd0);
      step();
      chk("nofwd_bub2_valid", 64'(idex_valid), 64'd0);
      mem_we = 1'b0; #1;
      chk("nofwd_clear_ready", 64'(id_ready), 64'd1);
      step();
      chk("nofwd_or_valid", 64'(idex_valid), 64'd1);
      chk("nofwd_or_reg1",  64'(idex_reg1),  64'h1004);
      chk("nofwd_or_reg2",  64'(idex_reg2),  64'h1004);
      chk("nofwd_or_waddr", 64'(idex_waddr), 64'd5);
`endif

      // Load-use: ADDU $7,$6,$0 behind a load to $6
      ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd6; ex_wdata = 32'hDEAD;
      mem_we = 1'b0;
      issue(32'h120, 32'h00C0_3821);
      chk("lu_ready", 64'(id_ready), 64'd0);
      step();
      chk("lu_bub_valid", 64'(idex_valid), 64'd0);
      chk("lu_bub_we",    64'(idex_we),    64'd0);
      ex_we = 1'b0; ex_is_load = 1'b0;
      mem_we = 1'b1; mem_waddr = 5'd6; mem_wdata = 32'h5555; #1;
`ifdef FORWARD_EN
      chk("lu_acc_ready", 64'(id_ready), 64'd1);
      step();
      exp_hold = 32'h5555;
`else
      chk("lu_mem_ready", 64'(id_ready), 64'd0);
      step();
      chk("lu_bub2_valid", 64'(idex_valid), 64'd0);
      mem_we = 1'b0; #1;
      chk("lu_acc_ready", 64'(id_ready), 64'd1);
      step();
      exp_hold = 32'h1006;
`endif
      chk("lu_valid", 64'(idex_valid), 64'd1);
      chk("lu_reg1",  64'(idex_reg1),  64'(exp_hold));
      chk("lu_reg2",  64'(idex_reg2),  64'd0);

      // EX back-pressure: latch holds, ID refuses, then flush mid-hold
      mem_we = 1'b0; ex_ready = 1'b0;
      issue(32'h124, 32'h3401_8001);
      for (int i = 0; i < 3; i++) begin
         chk("hold_ready", 64'(id_ready), 64'd0);
         step();
         chk("hold_valid", 64'(idex_valid), 64'd1);
         chk("hold_reg1",  64'(idex_reg1),  64'(exp_hold));
         chk("hold_waddr", 64'(idex_waddr), 64'd7);
         chk("hold_pc",    64'(idex_pc),    64'h120);
      end
      flush = 1'b1; #1;
      chk("flush_ready", 64'(id_ready), 64'd0);
      step();
      chk("flush_valid", 64'(idex_valid), 64'd0);
      chk("flush_we",    64'(idex_we),    64'd0);

      // Unknown opcode and write to $0: no sources, no stall even on a matching load
      flush = 1'b0; ex_ready = 1'b1;
      ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd1;
      issue(32'h130, 32'hFC00_0000);
      chk("unk_ready", 64'(id_ready), 64'd1);
      step();
      chk("unk_valid", 64'(idex_valid), 64'd1);
      chk("unk_we",    64'(idex_we),    64'd0);
      chk("unk_oper",  64'(idex_oper),  64'(OP_NOP));
      issue(32'h134, 32'h0022_0025);
      chk("r0_ready", 64'(id_ready), 64'd1);
      step();
      chk("r0_valid", 64'(idex_valid), 64'd1);
      chk("r0_we",    64'(idex_we),    64'd0);
      chk("r0_pc",    64'(idex_pc),    64'h134);

      // No instruction from IF while advancing: bubble
      ex_we = 1'b0; ex_is_load = 1'b0;
      if_valid = 1'b0;
      step();
      chk("idle_valid", 64'(idex_valid), 64'd0);

      // Flush together with reset behaves as reset
      issue(32'h140, 32'h3401_8001);
      step();
      chk("pre_rst_valid", 64'(idex_valid), 64'd1);
      rst = 1'b1; flush = 1'b1;
      step();
      chk("rstfl_valid", 64'(idex_valid), 64'd0);
      chk("rstfl_pc",    64'(idex_pc),    64'd0);
      chk("rstfl_reg2",  64'(idex_reg2),  64'd0);
      chk("rstfl_we",    64'(idex_we),    64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Pipelined MIPS instruction-decode stage sitting between the IF stage and EX. It decodes I-type and R-type ALU instructions and reads the register file. It resolves operands through EX/MEM bypassing and interlocks on load-use hazards. Results are held in a registered ID/EX pipeline latch with a valid/ready handshake, and EX drives a flush.

## Interface
- DATA_W, 32, operand/register width; must be ≥ 32; immediates extend to DATA_W
- REG_ADDR_W, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- if_valid  in  1  IF presents an instruction
- if_pc  in  32  PC of presented instruction
- if_inst  in  32  instruction word
- id_ready  out  1  ID accepts if_inst this cycle (combinational)
- rf_raddr1 / rf_raddr2  out  REG_ADDR_W  register file read addresses (combinational, = rs / rt)
- rf_rdata1 / rf_rdata2  in  DATA_W  register file read data (same cycle)
- ex_we, ex_waddr, ex_wdata, ex_is_load  in  1/REG_ADDR_W/DATA_W/1  instruction currently in EX
- mem_we, mem_waddr, mem_wdata  in  1/REG_ADDR_W/DATA_W  instruction currently in MEM
- ex_ready  in  1  EX consumes ID/EX latch this cycle
- flush  in  1  discard instruction in ID and ID/EX latch
- idex_valid  out  1  latch holds a valid instruction
- idex_pc  out  32;  idex_oper  out  Oper_t;  idex_reg1 / idex_reg2  out  DATA_W;  idex_we  out  1;  idex_waddr  out  REG_ADDR_W

## Operation
- Decode: ORI/ANDI/XORI zero-extend imm; ADDIU/SLTI sign-extend; LUI → reg2 = imm<<16, reg1 = 0; these write rt.
- SPECIAL funct OR/AND/XOR/ADDU/SUBU/SLT use rs and rt and write rd.
- Unknown opcode or funct → OP_NOP, we=0, no source used.
- Writes to register 0 force we=0.
- Operand source per used register: EX bypass if ex_we && ex_waddr==src && src≠0, else MEM bypass under the same rule, else rf_rdata. EX has priority over MEM.
- reg2 of I-type is the extended immediate. Unused sources are never compared for hazards.
- Load-use stall: ex_is_load && ex_we && ex_waddr≠0 && ex_waddr equals a used source.
  - On stall, id_ready=0 and a bubble is inserted into the latch when it advances.
- Latch advance condition: ex_ready || !idex_valid. When the latch is not advancing, id_ready=0 and the latch holds.
- id_ready = !stall && (ex_ready || !idex_valid) && !flush.

## Timing
- Decode and operand select are combinational. Latch latency is one cycle: an instruction accepted at edge N appears on idex_* after edge N.
- Reset: idex_valid=0, idex_oper=OP_NOP, idex_we=0, idex_waddr=0, idex_reg1=idex_reg2=0, idex_pc=0.
- Flush: idex_valid=0 after the next edge. if_inst is not accepted that cycle.
  - Flush overrides stall and ex_ready.
  - Flush in the same cycle as reset behaves as reset.
- Stall with advancing latch: the latch loads a bubble (valid=0, we=0, OP_NOP) and ID re-evaluates the held instruction next cycle.
- if_valid=0 with advancing latch: the latch loads a bubble.
- A back-to-back dependent ALU pair issues with no bubble (forwarding).
- A load followed by a dependent instruction gets exactly one bubble.

## Configuration
- FORWARD_EN defined: bypass and load-use interlock as above.
- FORWARD_EN undefined: no bypass; operands always come from rf_rdata.
  - Stall when any used nonzero source matches ex_waddr (ex_we) or mem_waddr (mem_we).
  - A dependent ALU pair receives two bubbles.
  - ex_wdata and mem_wdata are unused.

## Structure
- Shared package cpu_defines holds the following:
  - Oper_t enum (OP_NOP, OP_OR, OP_AND, OP_XOR, OP_ADDU, OP_SUBU, OP_SLT, OP_LUI)
  - OPCODE_* and FUNCT_* constants
  - Reg_addr_t, Inst_t, Inst_addr_t
- Sub-module id_decoder: purely combinational; inst → oper, use_rs, use_rt, imm_ext, we, waddr.
- id_stage itself holds the hazard/bypass logic and the ID/EX latch.

## Test plan
- Reset for 2 cycles, then ORI $1,$0,0x8001 with ex_ready=1 → idex_reg1=0, idex_reg2=0x00008001, idex_waddr=1, idex_we=1, idex_valid=1 one cycle after acceptance.
- ADDIU $2,$0,0xFFFF → idex_reg2=0xFFFFFFFF; LUI $3,0x1234 → idex_reg2=0x12340000.
- ex_we=1, ex_waddr=4, ex_wdata=0xAA and mem_we=1, mem_waddr=4, mem_wdata=0xBB; issue OR $5,$4,$4 → reg1=reg2=0xAA.
  - Same with ex_waddr=0 → 0xBB.
  - Without FORWARD_EN → id_ready=0 until both clear.
- ex_is_load=1, ex_waddr=6; issue ADDU $7,$6,$0 → id_ready=0 one cycle and a bubble in the latch; accepted the next cycle with the MEM-forwarded value.
- ex_ready=0 for 3 cycles while idex_valid=1 → idex_* stable, id_ready=0. Assert flush mid-hold → idex_valid=0 next cycle.
- Unknown opcode 0x3F and OR $0,$1,$2 → idex_we=0, no stall even when sources match ex_waddr.
